acc_delta_decoder: RTL and testbench

// Inverse of the accumulator: watches the stream of accumulator samples and recovers the
// (add_sub, data_in) operations that produced them. It differences each sample against the

---
 rtl/acc_delta_decoder.sv | 152 +++++++++++++++
 tb/tb_acc_delta_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_delta_decoder.sv
`default_nettype none
// ============================================================================
// Module  : acc_delta_decoder
// Brief   : Recovers (add_sub, operand) pairs from a stream of accumulator
//           samples by differencing consecutive samples; results are queued
//           in a small ready/valid output FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module acc_delta_decoder #(
   parameter int ACC_W      = 16,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              acc_valid,
   input  logic [ACC_W-1:0]  acc,
   output logic              acc_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              add_sub,
   output logic [DATA_W-1:0] data_out,
   output logic              range_err,
   input  logic              err_clr,
   output logic [15:0]       sample_cnt
);

   localparam int                AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]       c_depth   = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0]     c_ptr_one = 1;
   localparam logic [ACC_W-1:0]  c_op_max  = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
   localparam logic [15:0]       c_cnt_max = 16'hFFFF;

   typedef enum logic [0:0] {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ACC_W-1:0]  r_prev;
   logic [ACC_W-1:0]  w_prev_nxt;
   logic [DATA_W:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              r_range_err;
   logic [15:0]       r_sample_cnt;

   logic              w_full;
   logic              w_accept;
   logic              w_pop;
   logic              w_push;
   logic              w_err_set;
   logic [ACC_W-1:0]  w_diff;
   logic              w_neg;
   logic [ACC_W-1:0]  w_mag;
   logic              w_in_range;

   assign w_full    = (r_count == c_depth);
   assign acc_ready = ~w_full;
   assign out_valid = (r_count != '0);
   assign w_accept  = acc_valid & ~w_full;
   assign w_pop     = out_valid & out_ready;

   // Magnitude of the signed modular step; the most negative value maps to
   // itself and is therefore always out of range.
   assign w_diff     = acc - r_prev;
   assign w_neg      = w_diff[ACC_W-1];
   assign w_mag      = w_neg ? -w_diff : w_diff;
   assign w_in_range = (w_mag <= c_op_max);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_PRIME;
         r_prev  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_prev  <= w_prev_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_prev_nxt  = r_prev;
      w_push      = 1'b0;
      w_err_set   = 1'b0;
      if (clr) begin
         // A sample in the same cycle is consumed but never decoded.
         w_state_nxt = ST_RUN;
         w_prev_nxt  = '0;
      end else if (w_accept) begin
         w_prev_nxt = acc;
         case (r_state)
            ST_PRIME: w_state_nxt = ST_RUN;
            ST_RUN: begin
               w_push    = w_in_range;
               w_err_set = ~w_in_range;
            end
            default: w_state_nxt = ST_PRIME;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_neg, w_mag[DATA_W-1:0]};
            r_wr_ptr        <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_range_err  <= 1'b0;
         r_sample_cnt <= '0;
      end else begin
         if (w_err_set) begin
            r_range_err <= 1'b1;
         end else if (err_clr) begin
            r_range_err <= 1'b0;
         end
         if (w_push && (r_sample_cnt != c_cnt_max)) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
         end
      end
   end

   assign add_sub    = r_mem[r_rd_ptr][DATA_W];
   assign data_out   = r_mem[r_rd_ptr][DATA_W-1:0];
   assign range_err  = r_range_err;
   assign sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_acc_delta_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_acc_delta_decoder
// Brief   : Directed table, corner sequences and a random run against a
//           queue-based reference model for acc_delta_decoder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_acc_delta_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        acc_valid = 1'b0;
   logic [15:0] acc = '0;
   logic        acc_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        add_sub;
   logic [7:0]  data_out;
   logic        range_err;
   logic        err_clr = 1'b0;
   logic [15:0] sample_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   acc_delta_decoder #(.ACC_W(16), .DATA_W(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .clr(clr), .acc_valid(acc_valid), .acc(acc),
      .acc_ready(acc_ready), .out_valid(out_valid), .out_ready(out_ready),
      .add_sub(add_sub), .data_out(data_out), .range_err(range_err),
      .err_clr(err_clr), .sample_cnt(sample_cnt)
   );

   typedef struct {
      logic        c, v;
      logic [15:0] a;
      logic        r, e;
      logic        x_valid, x_as;
      logic [7:0]  x_data;
      logic        x_err;
      logic [15:0] x_cnt;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; clr = 1'b0; acc_valid = 1'b0; acc = '0; out_ready = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic step(input logic c, input logic v, input logic [15:0] a,
                       input logic r, input logic e);
      clr = c; acc_valid = v; acc = a; out_ready = r; err_clr = e;
      @(negedge clk);
   endtask

   // Reference model state
   int m_q[$];
   int m_prev;
   bit m_prime;
   bit m_err;
   int m_cnt;

   task automatic model_reset();
      m_q.delete(); m_prev = 0; m_prime = 1; m_err = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input bit c, input bit v, input int a, input bit r, input bit e);
      bit accept, set_err;
      int d;
      accept  = v && (m_q.size() < 4);
      set_err = 0;
      if (r && m_q.size() > 0) void'(m_q.pop_front());
      if (c) begin
         m_prev = 0; m_prime = 0;
      end else if (accept) begin
         if (m_prime) begin
            m_prime = 0;
         end else begin
            d = (a - m_prev + 65536) % 65536;
            if (d >= 32768) d -= 65536;
            if (d >= 0 && d <= 255) m_q.push_back(d);
            else if (d < 0 && d >= -255) m_q.push_back(256 + (-d));
            else set_err = 1;
            if (!set_err && m_cnt < 65535) m_cnt++;
         end
         m_prev = a;
      end
      if (set_err) m_err = 1;
      else if (e) m_err = 0;
   endtask

   task automatic model_check();
      chk("rnd_out_valid", out_valid, m_q.size() > 0);
      chk("rnd_acc_ready", acc_ready, m_q.size() < 4);
      chk("rnd_range_err", range_err, m_err);
      chk("rnd_sample_cnt", sample_cnt, m_cnt);
      if (m_q.size() > 0) begin
         chk("rnd_add_sub", add_sub, m_q[0] / 256);
         chk("rnd_data_out", data_out, m_q[0] % 256);
      end
   endtask

   initial begin
      int got[$];
      bit acc_now;
      vecs[0]  = '{1,0,16'h0000,0,0, 0,0,8'h00,0,16'd0};
      vecs[1]  = '{0,1,16'h0005,0,0, 1,0,8'h05,0,16'd1};
      vecs[2]  = '{0,1,16'h000F,1,0, 1,0,8'h0A,0,16'd2};
      vecs[3]  = '{0,1,16'h000C,1,0, 1,1,8'h03,0,16'd3};
      vecs[4]  = '{0,1,16'h0008,1,0, 1,1,8'h04,0,16'd4};
      vecs[5]  = '{0,1,16'hFFFE,1,0, 1,1,8'h0A,0,16'd5};
      vecs[6]  = '{0,1,16'h0003,1,0, 1,0,8'h05,0,16'd6};
      vecs[7]  = '{0,1,16'h0002,1,0, 1,1,8'h01,0,16'd7};
      vecs[8]  = '{0,1,16'hFFFF,1,0, 1,1,8'h03,0,16'd8};
      vecs[9]  = '{1,0,16'h0000,1,0, 0,0,8'h00,0,16'd8};
      vecs[10] = '{0,1,16'h0100,1,0, 0,0,8'h00,1,16'd8};
      vecs[11] = '{0,1,16'h0101,1,0, 1,0,8'h01,1,16'd9};
      vecs[12] = '{0,0,16'h0000,1,1, 0,0,8'h00,0,16'd9};
      vecs[13] = '{0,1,16'h0301,1,0, 0,0,8'h00,1,16'd9};
      vecs[14] = '{0,1,16'h0501,1,1, 0,0,8'h00,1,16'd9};
      vecs[15] = '{0,0,16'h0000,1,1, 0,0,8'h00,0,16'd9};
      vecs[16] = '{0,1,16'h0600,1,0, 1,0,8'hFF,0,16'd10};
      vecs[17] = '{0,1,16'h0501,1,0, 1,1,8'hFF,0,16'd11};
      vecs[18] = '{0,1,16'h0401,1,0, 0,0,8'h00,1,16'd11};
      vecs[19] = '{0,1,16'h0401,1,0, 1,0,8'h00,1,16'd12};

      // Reset state
      do_reset();
      chk("rst_acc_ready", acc_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_add_sub", add_sub, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_range_err", range_err, 0);
      chk("rst_sample_cnt", sample_cnt, 0);

      // Directed table: each row is one clock edge
      for (int i = 0; i < 20; i++) begin
         step(vecs[i].c, vecs[i].v, vecs[i].a, vecs[i].r, vecs[i].e);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].x_valid);
         chk($sformatf("tbl%0d_acc_ready", i), acc_ready, 1);
         chk($sformatf("tbl%0d_range_err", i), range_err, vecs[i].x_err);
         chk($sformatf("tbl%0d_sample_cnt", i), sample_cnt, vecs[i].x_cnt);
         if (vecs[i].x_valid) begin
            chk($sformatf("tbl%0d_add_sub", i), add_sub, vecs[i].x_as);
            chk($sformatf("tbl%0d_data_out", i), data_out, vecs[i].x_data);
         end
      end

      // Full FIFO backpressure and ordering (deltas 1..5)
      do_reset();
      step(1, 0, 16'h0000, 0, 0);
      step(0, 1, 16'd1, 0, 0);
      step(0, 1, 16'd3, 0, 0);
      step(0, 1, 16'd6, 0, 0);
      step(0, 1, 16'd10, 0, 0);
      chk("full_acc_ready", acc_ready, 0);
      chk("full_sample_cnt", sample_cnt, 4);
      clr = 0; acc_valid = 1; acc = 16'd15; out_ready = 1;
      chk("full_no_push_on_pop", acc_ready, 0);
      for (int n = 0; n < 20 && got.size() < 5; n++) begin
         acc_now = acc_valid && acc_ready;
         if (out_valid) got.push_back(int'(data_out));
         @(negedge clk);
         if (acc_now) acc_valid = 0;
      end
      chk("full_drain_count", got.size(), 5);
      for (int k = 0; k < 5 && k < got.size(); k++)
         chk($sformatf("full_order%0d", k), got[k], k + 1);
      chk("full_final_cnt", sample_cnt, 5);

      // Prime without clr, then clr colliding with a sample
      do_reset();
      step(0, 1, 16'h1234, 0, 0);
      chk("prime_no_entry", out_valid, 0);
      chk("prime_cnt", sample_cnt, 0);
      step(0, 1, 16'h1240, 0, 0);
      chk("prime_next_valid", out_valid, 1);
      chk("prime_next_data", data_out, 8'h0C);
      step(1, 1, 16'h7777, 0, 0);
      chk("clr_sample_cnt", sample_cnt, 1);
      step(0, 1, 16'h0003, 0, 0);
      chk("clr_prev_cnt", sample_cnt, 2);
      chk("clr_head_data", data_out, 8'h0C);
      step(0, 0, 16'h0000, 1, 0);
      chk("clr_prev_zero_data", data_out, 8'h03);
      chk("clr_prev_zero_as", add_sub, 0);

      // Reset pulsed mid-stream
      do_reset();
      step(1, 0, 16'h0000, 0, 0);
      step(0, 1, 16'h0010, 0, 0);
      step(0, 1, 16'h0020, 0, 0);
      chk("mid_two_cnt", sample_cnt, 2);
      acc_valid = 0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_out_valid", out_valid, 0);
      chk("mid_sample_cnt", sample_cnt, 0);
      chk("mid_data_out", data_out, 0);
      @(negedge clk);
      rst = 1'b1;
      step(0, 1, 16'h0050, 0, 0);
      chk("mid_prime_no_entry", out_valid, 0);
      step(0, 1, 16'h0052, 0, 0);
      chk("mid_after_data", data_out, 8'h02);
      chk("mid_after_cnt", sample_cnt, 1);

      // Randomized run against the reference model
      do_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         int sel, delta;
         bit c, v, r, e;
         int a;
         sel = int'($urandom_range(0, 9));
         if (sel < 8)       a = (m_prev + int'($urandom_range(0, 510)) - 255 + 65536) % 65536;
         else if (sel == 8) a = (m_prev + int'($urandom_range(256, 2000)) * (($urandom % 2) ? 1 : -1) + 65536) % 65536;
         else               a = int'($urandom_range(0, 65535));
         delta = 0;
         c = ($urandom % 32) == 0;
         v = ($urandom % 4) != 0;
         r = ($urandom % 3) != 0;
         e = ($urandom % 16) == 0;
         model_edge(c, v, a + delta, r, e);
         step(c, v, 16'(a + delta), r, e);
         model_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
